pickup_train_station: RTL
=========================

# pickup_train_station

Supply-side counterpart of the dropoff station in the train-balancer network. It manages the pickup stop: it publishes a train limit from local stock, holds a loaded train until the global network shows unfilled dropoff demand, then releases it. While the departing train is not yet counted as en route at any dropoff, it claims one slot on the global red network so other pickups do not over-dispatch. Sits beside the pickup train stop; `d` and `k` come from the same global green/red lines the dropoff stations drive.

## Interface
- `Q`, 3: maximum trains allowed to queue at this pickup stop.
- `W`, 8000: units per train load.
- `HOLD`, 4: cycles the slot claim is kept after the train leaves.
- `PRI`, 0: arbitration stagger; cycles of continuous demand required before release.
- `TL`, 600: loading timeout in cycles; used only with `PICKUP_LOAD_TIMEOUT_EN`.
- `INT`, 31: MSB index of all data ports.

- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `t` input INT+1: train ID at stop; nonzero means a train is present.
- `f` input INT+1: cargo contents of the train at the stop.
- `u` input INT+1: pickup buffer contents.
- `d` input INT+1: global demand, the sum of `L` from all dropoffs (green).
- `k` input INT+1: global en-route count, the sum of dropoff `C` plus every pickup `s` (red).
- `l` output INT+1: train limit to the stop.
- `go` output 1: departure signal to the train stop.
- `s` output INT+1: slot claim onto red, either 0 or 1.

## Operation
- All data ports are signed two's complement, and all comparisons are signed. Free slots are defined as `d - k`, computed at INT+2 bits so it cannot overflow.
- `l` is registered and recomputed every cycle in every state:
  - if `u <= 0`, `l = 0`;
  - otherwise `l = min(u / W, Q)`, with truncating division.
- The FSM has five states: EMPTY, LOADING, READY, DEPART, COOLDOWN.
  - EMPTY: `go=0`, `s=0`. If `t != 0`, go to LOADING.
  - LOADING: `go=0`, `s=0`. If `t == 0`, go to EMPTY (train left early). Else if `f >= W`, go to READY.
  - READY: `go=0`, `s=0`. A stagger counter `z` counts consecutive cycles with `d > k`. `z` clears on entry and whenever `d <= k`. When `d > k` and `z >= PRI`, go to DEPART. If `t == 0`, go to EMPTY; this check takes priority over release.
  - DEPART: `go=1`, `s=1`. When `t == 0`, load `HOLD` into the cooldown counter and go to COOLDOWN.
  - COOLDOWN: `go=0`, `s=1`. The counter decrements each cycle; at 0, go to EMPTY. A new train arriving (`t != 0`) does not shorten COOLDOWN; it is picked up from EMPTY on the next cycle.
- A new `t` value while in LOADING/READY/DEPART with `t` still nonzero (ID swap without a zero cycle) is treated as the same occupancy.
- `PRI` values are unique per pickup station. Equal `PRI` may double-release; this is accepted and self-corrects through `k` at the next decision.

## Timing
- Reset: state is EMPTY, `l=0`, `go=0`, `s=0`, and all counters are 0. `rst` asserted mid-DEPART drops `go` and `s` the following cycle.
- All outputs are registered; the earliest response to any input change is one cycle later.
- Release latency from READY with `d > k` held: `PRI+1` cycles to `go=1`. With `PRI=0`, `go` rises on the cycle after `d > k` is first sampled.
- `go` stays high until the cycle after `t` is sampled at 0.
- `s=1` spans the whole of DEPART plus exactly `HOLD` COOLDOWN cycles, then falls on the EMPTY transition edge.
- A train arriving with `f >= W` already satisfied still spends one cycle in LOADING: EMPTY, then LOADING, then READY.

## Configuration
- `PICKUP_LOAD_TIMEOUT_EN` defined:
  - LOADING runs a counter that clears on entry.
  - When the counter reaches `TL` with `f > 0`, the FSM goes to READY and dispatches a partial load.
  - With `f <= 0` it stays in LOADING, and the counter saturates at `TL`.
- `PICKUP_LOAD_TIMEOUT_EN` undefined:
  - There is no counter.
  - LOADING exits only on `f >= W` or `t == 0`.
  - `TL` is ignored.

## Test plan
- Limit: `u` = -5, 0, 7999, 8000, 20000, 40000 → `l` = 0, 0, 0, 1, 2, 3 respectively, each one cycle later.
- Basic dispatch (`PRI=0`, `HOLD=4`): `t=7`, `f` steps 0→8000, `d=2`, `k=1` → LOADING, then READY, then `go=1` and `s=1` the next cycle. Drop `t` to 0 → `go=0` next cycle, `s=1` for 4 cycles, then 0.
- Stagger (`PRI=2`): READY with `d=1`, `k=0`, but `k` pulses to 1 on the second cycle → `z` restarts. `go` rises only after 3 consecutive `d > k` samples.
- No demand: READY with `d=3`, `k=3` held for 1000 cycles → `go=0` and `s=0` throughout. Then `t` drops to 0 → EMPTY with no claim.
- Reset mid-operation: assert `rst` in DEPART → next cycle `go=0`, `s=0`, `l=0`, state EMPTY. Deassert with `t` nonzero → LOADING.
- Timeout (macro on, `TL=10`): `t=1`, `f=500` held → READY after 10 LOADING cycles. With `f=0` → stays in LOADING indefinitely. Macro off: `f=500` → never leaves LOADING.

Source files
------------

// File: rtl/pickup_train_station.sv
// Pickup stop controller: publishes a train limit, holds loaded trains until global demand exists,
// then releases them while claiming a red slot. Optional load timeout: PICKUP_LOAD_TIMEOUT_EN.
module pickup_train_station #(
  parameter int Q    = 3,
  parameter int W    = 8000,
  parameter int HOLD = 4,
  parameter int PRI  = 0,
  parameter int TL   = 600,
  parameter int INT  = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [INT:0] t,
  input  logic [INT:0] f,
  input  logic [INT:0] u,
  input  logic [INT:0] d,
  input  logic [INT:0] k,
  output logic [INT:0] l,
  output logic         go,
  output logic [INT:0] s,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    EMPTY    = 3'd0,
    LOADING  = 3'd1,
    READY    = 3'd2,
    DEPART   = 3'd3,
    COOLDOWN = 3'd4
  } state_t;

  localparam logic signed [INT:0] W_S    = (INT+1)'(W);
  localparam logic signed [INT:0] Q_S    = (INT+1)'(Q);
  localparam logic [31:0]         PRI_C  = 32'(PRI);
  localparam logic [31:0]         HOLD_C = 32'(HOLD);

  state_t state, next;
  logic [31:0] z;
  logic [31:0] cd_cnt;

  logic signed [INT:0]   u_s, f_s, q;
  logic signed [INT+1:0] free;
  logic                  t_present, full, f_pos, demand;
  logic [INT:0]          lim_nxt;

  // Free slots use one extra bit so d - k can never wrap.
  always_comb begin
    u_s       = $signed(u);
    f_s       = $signed(f);
    q         = u_s / W_S;
    free      = $signed({d[INT], d}) - $signed({k[INT], k});
    t_present = (t != '0);
    full      = (f_s >= W_S);
    f_pos     = !f[INT] && (f != '0);
    demand    = !free[INT+1] && (free != '0);
    if (u[INT] || u == '0)
      lim_nxt = '0;
    else if (q > Q_S)
      lim_nxt = Q_S;
    else
      lim_nxt = q;
  end

`ifdef PICKUP_LOAD_TIMEOUT_EN
  localparam logic [31:0] TL_C = 32'(TL);
  logic [31:0] ld_cnt;
  logic        ld_timeout;
  assign ld_timeout = (ld_cnt + 32'd1 >= TL_C) && f_pos;

  // Counts LOADING cycles from entry and saturates at TL.
  always_ff @(posedge clk) begin
    if (rst || state != LOADING) ld_cnt <= '0;
    else if (ld_cnt < TL_C)      ld_cnt <= ld_cnt + 32'd1;
  end
`else
  logic ld_timeout;
  assign ld_timeout = 1'b0;
`endif

  always_comb begin
    next = state;
    case (state)
      EMPTY:    if (t_present) next = LOADING;
      LOADING:  if (!t_present) next = EMPTY;
                else if (full || ld_timeout) next = READY;
      // Train leaving takes priority over release.
      READY:    if (!t_present) next = EMPTY;
                else if (demand && z >= PRI_C) next = DEPART;
      DEPART:   if (!t_present) next = (HOLD_C == 32'd0) ? EMPTY : COOLDOWN;
      COOLDOWN: if (cd_cnt <= 32'd1) next = EMPTY;
      default:  next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      l      <= '0;
      go     <= 1'b0;
      s      <= '0;
      z      <= '0;
      cd_cnt <= '0;
    end else begin
      state <= next;
      l     <= lim_nxt;
      go    <= (next == DEPART);
      s     <= {{INT{1'b0}}, (next == DEPART) || (next == COOLDOWN)};
      if (state == READY && next == READY && demand) z <= z + 32'd1;
      else                                          z <= '0;
      // Cooldown holds the claim for exactly HOLD cycles after the train leaves.
      if (state == DEPART && next == COOLDOWN) cd_cnt <= HOLD_C;
      else if (state == COOLDOWN && cd_cnt != '0) cd_cnt <= cd_cnt - 32'd1;
      else cd_cnt <= '0;
    end
  end

  assign dbg_state = state;

endmodule
